cmd_router: RTL and testbench
=============================

# cmd_router

Parametrised successor to the fixed front-panel command decoder. It parses framed control bytes, each frame being `{opcode, subtype, header..., payload...}`. The block routes each frame's payload to one of `NUM_CH` one-hot output strobes on a shared data bus, discards malformed frames and counts them, and optionally echoes read frames on a reply port. It sits between the control-interface byte receiver and the SI/NIT/frequency/IP-port configuration blocks.

## Interface
- `DW`, 8, byte width of data buses.
- `NUM_CH`, 8, number of routed channels; power of two, at least 2.
- `CNT_W`, 16, width of the in-frame byte counter; saturates at all-ones.
- `SKIP_VEC`, `{NUM_CH{8'd4}}`, packed 8-bit per-channel payload start index; channel c uses `SKIP_VEC[8c+7:8c]`, which must be at least 2.
- `REPLY_LEN`, 8, number of bytes echoed per read frame.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `con_din` in DW: frame byte.
- `con_din_en` in 1: high for every byte of a frame, contiguous; a low cycle ends the frame.
- `route_dout` out DW: payload byte; 0 when no strobe is active.
- `route_en` out NUM_CH: one-hot payload strobe.
- `frame_done` out 1: one-cycle pulse when a routed frame ends.
- `frame_ch` out clog2(NUM_CH): channel of the last routed frame; held until the next routed frame.
- `len_err` out 1: one-cycle pulse when a routed frame ends before any payload byte.
- `bad_cmd_cnt` out 16: saturating count of discarded frames.
- `reply_dout` out DW: echoed byte (only with the macro).
- `reply_en` out 1: echo strobe (only with the macro).

## Operation
- `en_d` holds the previous-cycle `con_din_en`; reset sets it to 1. A frame start is `con_din_en & ~en_d`, so a frame still in flight at reset release is ignored.
- Byte index `k`:
  - 0 on the frame-start byte.
  - Increments on each later enabled byte.
  - Saturates at `2^CNT_W-1`.
  - Returns to 0 when `con_din_en` is low.
- States are `IDLE`, `OPCODE`, `ROUTE`, `DISCARD`.
- `IDLE`: on frame start, go to `OPCODE` if the byte is 0x04 (read) or 0x40 (write). Any other start byte goes to `DISCARD` and increments `bad_cmd_cnt`.
- `OPCODE` (evaluates byte k=1):
  - If `con_din_en` is low: go to `IDLE` and increment `bad_cmd_cnt`.
  - Else if subtype < `NUM_CH/2`: latch channel `ch = {opcode==0x40, subtype[clog2(NUM_CH)-2:0]}` and go to `ROUTE`.
  - Otherwise: go to `DISCARD` and increment `bad_cmd_cnt`.
- `ROUTE`:
  - Each enabled byte with `k >= SKIP_VEC[ch]` drives `route_dout = con_din` and `route_en = 1<<ch` on the next cycle.
  - When `con_din_en` goes low: go to `IDLE`, pulse `frame_done`, and update `frame_ch`. Also pulse `len_err` if no payload byte was forwarded.
- `DISCARD`: outputs stay 0; go to `IDLE` when `con_din_en` goes low.
- `bad_cmd_cnt` holds at 0xFFFF once saturated.
- Reset mid-frame:
  - State goes to `IDLE` and all outputs go to 0 on the next edge.
  - `bad_cmd_cnt` clears to 0.
  - The in-flight remainder is not counted as bad.
- Simultaneous events: when `con_din_en` drops and rises again in consecutive cycles (a 1-cycle gap), the end of the old frame and the start of the new one are both processed; no byte is lost.

## Timing
- Reset values: `route_dout`=0, `route_en`=0, `frame_done`=0, `frame_ch`=0, `len_err`=0, `bad_cmd_cnt`=0, `reply_dout`=0, `reply_en`=0, state=`IDLE`.
- Payload latency is 1 cycle, from the `con_din` edge to `route_dout`/`route_en`. Throughput is 1 byte per cycle, with no back-pressure.
- `frame_done` and `len_err` assert 1 cycle after the first low `con_din_en` cycle, in the same cycle the last payload byte leaves the output register + 1.
- The `bad_cmd_cnt` increment is visible 1 cycle after the deciding byte.

## Configuration
- `CMD_ROUTER_REPLY_EN` defined:
  - For frames with opcode 0x04 that reach `ROUTE`, bytes k=0 … `REPLY_LEN-1` are echoed on `reply_dout`/`reply_en` with 2-cycle latency.
  - Echo stops early if the frame ends first.
  - The k=0 and k=1 bytes are held in a 2-stage delay line.
- Macro not defined: the reply logic is not built, and `reply_dout`/`reply_en` are tied to 0.

## Test plan
- Default parameters; frame 0x40,0x01,AA,BB,C0,C1,C2 → `route_en`=0x20 for 3 cycles carrying C0,C1,C2 at 1-cycle latency; then `frame_done`=1 with `frame_ch`=5.
- Frame 0x04,0x02,x,x,D0 → `route_en`=0x04 for 1 cycle with D0. With the macro, `reply_en` is high for 5 cycles echoing 0x04,0x02,x,x,D0 at 2-cycle latency.
- Frames 0x33,… / 0x40,0x07,… / single byte 0x04 → no `route_en`; `bad_cmd_cnt` goes 0→1→2→3.
- Frame 0x40,0x00,11,22 (length < `SKIP`) → no `route_en`; `frame_done`=1, `len_err`=1, `frame_ch`=4.
- Two frames separated by a 1-cycle `con_din_en` gap → both routed fully, with two `frame_done` pulses.
- `rst` asserted for 1 cycle mid-payload, with `con_din_en` still high → outputs 0 next cycle; the rest of that frame is not routed and not counted; the following frame routes normally.

Source files
------------

// File: rtl/cmd_router.sv
// Frame parser: routes payload bytes to one-hot channel strobes, 1-cycle latency, no back-pressure.
// Optional read-frame echo port is built only when CMD_ROUTER_REPLY_EN is defined.
module cmd_router #(
  parameter int                  DW        = 8,
  parameter int                  NUM_CH    = 8,
  parameter int                  CNT_W     = 16,
  parameter logic [8*NUM_CH-1:0] SKIP_VEC  = {NUM_CH{8'd4}},
  parameter int                  REPLY_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             con_din,
  input  logic                      con_din_en,
  output logic [DW-1:0]             route_dout,
  output logic [NUM_CH-1:0]         route_en,
  output logic                      frame_done,
  output logic [$clog2(NUM_CH)-1:0] frame_ch,
  output logic                      len_err,
  output logic [15:0]               bad_cmd_cnt,
  output logic [DW-1:0]             reply_dout,
  output logic                      reply_en
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [DW-1:0] OP_RD = DW'(8'h04);
  localparam logic [DW-1:0] OP_WR = DW'(8'h40);

  typedef enum logic [1:0] {IDLE, OPCODE, ROUTE, DISCARD} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, k;
  logic              is_wr_q, is_wr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              fwd_q, fwd_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic [NUM_CH-1:0] ren_q, ren_d;
  logic              done_q, done_d;
  logic              lerr_q, lerr_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic [15:0]       bad_q;
  logic              bad_inc;
  logic              start, cmd_ok, sub_ok, pay_ok;
  logic [7:0]        skip_sel;

  // en_q resets high so a frame already in flight at reset release is not seen as a start.
  assign start    = con_din_en & ~en_q;
  assign k        = start ? '0 : cnt_q;
  assign cnt_d    = !con_din_en ? '0 : ((&k) ? k : k + 1'b1);
  assign cmd_ok   = (con_din == OP_RD) || (con_din == OP_WR);
  assign sub_ok   = con_din < DW'(NUM_CH / 2);
  assign skip_sel = SKIP_VEC[8*ch_q +: 8];
  assign pay_ok   = 32'(k) >= 32'(skip_sel);

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    ch_d    = ch_q;
    fwd_d   = fwd_q;
    dout_d  = '0;
    ren_d   = '0;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    fch_d   = fch_q;
    bad_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_ok) begin
            state_d = OPCODE;
            is_wr_d = (con_din == OP_WR);
          end else begin
            state_d = DISCARD;
            bad_inc = 1'b1;
          end
        end
      end
      OPCODE: begin
        if (!con_din_en) begin
          state_d = IDLE;
          bad_inc = 1'b1;
        end else if (sub_ok) begin
          state_d = ROUTE;
          // Writes occupy the upper half of the channel space, reads the lower half.
          ch_d    = (is_wr_q ? CH_W'(NUM_CH / 2) : '0) | con_din[CH_W-1:0];
          fwd_d   = 1'b0;
        end else begin
          state_d = DISCARD;
          bad_inc = 1'b1;
        end
      end
      ROUTE: begin
        if (con_din_en) begin
          if (pay_ok) begin
            dout_d = con_din;
            ren_d  = NUM_CH'(1) << ch_q;
            fwd_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          fch_d   = ch_q;
          lerr_d  = ~fwd_q;
        end
      end
      DISCARD: begin
        if (!con_din_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b1;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      ch_q    <= '0;
      fwd_q   <= 1'b0;
      dout_q  <= '0;
      ren_q   <= '0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
      fch_q   <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= con_din_en;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      ch_q    <= ch_d;
      fwd_q   <= fwd_d;
      dout_q  <= dout_d;
      ren_q   <= ren_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
      fch_q   <= fch_d;
      if (bad_inc && (bad_q != 16'hFFFF)) bad_q <= bad_q + 16'd1;
    end
  end

  assign route_dout  = dout_q;
  assign route_en    = ren_q;
  assign frame_done  = done_q;
  assign frame_ch    = fch_q;
  assign len_err     = lerr_q;
  assign bad_cmd_cnt = bad_q;

`ifdef CMD_ROUTER_REPLY_EN
  logic          s1_vld_q, s1_vld_d, s1_tent_q, s1_tent_d;
  logic [DW-1:0] s1_dat_q;
  logic          rp_vld_q, rp_vld_d;
  logic [DW-1:0] rp_dat_q, rp_dat_d;
  logic          rd_go;

  // The opcode byte is held tentatively until the subtype confirms a routed read.
  assign rd_go     = (state_q == OPCODE) && con_din_en && sub_ok && !is_wr_q;
  assign s1_tent_d = (state_q == IDLE) && start && (con_din == OP_RD) && (REPLY_LEN > 0);
  assign s1_vld_d  = s1_tent_d || (rd_go && (REPLY_LEN > 1)) ||
                     ((state_q == ROUTE) && con_din_en && !is_wr_q && (32'(k) < 32'(REPLY_LEN)));
  assign rp_vld_d  = s1_vld_q && (!s1_tent_q || rd_go);
  assign rp_dat_d  = rp_vld_d ? s1_dat_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_tent_q <= 1'b0;
      s1_dat_q  <= '0;
      rp_vld_q  <= 1'b0;
      rp_dat_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_tent_q <= s1_tent_d;
      s1_dat_q  <= con_din;
      rp_vld_q  <= rp_vld_d;
      rp_dat_q  <= rp_dat_d;
    end
  end

  assign reply_dout = rp_dat_q;
  assign reply_en   = rp_vld_q;
`else
  logic unused_reply_len;
  assign unused_reply_len = (REPLY_LEN == 0);
  assign reply_dout = '0;
  assign reply_en   = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_router.sv
// Directed bench for cmd_router with default parameters; reply checks adapt to CMD_ROUTER_REPLY_EN.
module tb_cmd_router;

`ifdef CMD_ROUTER_REPLY_EN
  localparam bit HAS_REPLY = 1'b1;
`else
  localparam bit HAS_REPLY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] con_din;
  logic       con_din_en;
  logic [7:0] route_dout;
  logic [7:0] route_en;
  logic       frame_done;
  logic [2:0] frame_ch;
  logic       len_err;
  logic [15:0] bad_cmd_cnt;
  logic [7:0] reply_dout;
  logic       reply_en;

  int checks = 0;
  int errors = 0;

  cmd_router dut (
    .clk         (clk),
    .rst         (rst),
    .con_din     (con_din),
    .con_din_en  (con_din_en),
    .route_dout  (route_dout),
    .route_en    (route_en),
    .frame_done  (frame_done),
    .frame_ch    (frame_ch),
    .len_err     (len_err),
    .bad_cmd_cnt (bad_cmd_cnt),
    .reply_dout  (reply_dout),
    .reply_en    (reply_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input cycle; returns 1 time unit after the edge that samples it.
  task automatic drive(input logic en, input logic [7:0] din);
    con_din_en = en;
    con_din    = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    con_din_en = 1'b0;
    con_din    = 8'h00;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    chk("rst_route_en",   route_en,    0);
    chk("rst_route_dout", route_dout,  0);
    chk("rst_frame_done", frame_done,  0);
    chk("rst_frame_ch",   frame_ch,    0);
    chk("rst_len_err",    len_err,     0);
    chk("rst_bad_cnt",    bad_cmd_cnt, 0);
    chk("rst_reply_en",   reply_en,    0);
    chk("rst_reply_dout", reply_dout,  0);
    rst = 1'b0;
    drive(1'b0, 8'h00);

    // Write, subtype 1 -> channel 5, payload from index 4.
    drive(1'b1, 8'h40);
    chk("w_op_route_en", route_en, 0);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'hBB);
    chk("w_hdr_route_en", route_en, 0);
    drive(1'b1, 8'hC0);
    chk("w_c0_en",   route_en,   8'h20);
    chk("w_c0_dout", route_dout, 8'hC0);
    chk("w_reply_en", reply_en, 0);
    drive(1'b1, 8'hC1);
    chk("w_c1_dout", route_dout, 8'hC1);
    drive(1'b1, 8'hC2);
    chk("w_c2_en",   route_en,   8'h20);
    chk("w_c2_dout", route_dout, 8'hC2);
    drive(1'b0, 8'h00);
    chk("w_end_route_en", route_en,   0);
    chk("w_end_dout",     route_dout, 0);
    chk("w_done",         frame_done, 1);
    chk("w_frame_ch",     frame_ch,   5);
    chk("w_len_err",      len_err,    0);
    drive(1'b0, 8'h00);
    chk("w_done_pulse", frame_done, 0);
    chk("w_ch_hold",    frame_ch,   5);

    // Read, subtype 2 -> channel 2, with 2-cycle echo when built.
    drive(1'b1, 8'h04);
    chk("r_k0_reply_en", reply_en, 0);
    drive(1'b1, 8'h02);
    chk("r_echo0_en",  reply_en,   HAS_REPLY);
    chk("r_echo0_dat", reply_dout, HAS_REPLY ? 8'h04 : 8'h00);
    drive(1'b1, 8'h11);
    chk("r_echo1_dat", reply_dout, HAS_REPLY ? 8'h02 : 8'h00);
    drive(1'b1, 8'h22);
    chk("r_echo2_dat", reply_dout, HAS_REPLY ? 8'h11 : 8'h00);
    drive(1'b1, 8'hD0);
    chk("r_d0_en",     route_en,   8'h04);
    chk("r_d0_dout",   route_dout, 8'hD0);
    chk("r_echo3_dat", reply_dout, HAS_REPLY ? 8'h22 : 8'h00);
    drive(1'b0, 8'h00);
    chk("r_done",      frame_done, 1);
    chk("r_frame_ch",  frame_ch,   2);
    chk("r_end_en",    route_en,   0);
    chk("r_echo4_en",  reply_en,   HAS_REPLY);
    chk("r_echo4_dat", reply_dout, HAS_REPLY ? 8'hD0 : 8'h00);
    drive(1'b0, 8'h00);
    chk("r_echo_stop", reply_en, 0);

    // Malformed frames: bad opcode, subtype out of range, opcode-only.
    drive(1'b1, 8'h33);
    chk("bad1_cnt", bad_cmd_cnt, 1);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b1, 8'h44);
    drive(1'b1, 8'h55);
    chk("bad1_route_en", route_en, 0);
    drive(1'b0, 8'h00);
    chk("bad1_done", frame_done, 0);
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h07);
    chk("bad2_cnt", bad_cmd_cnt, 2);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    chk("bad2_route_en", route_en, 0);
    drive(1'b0, 8'h00);
    chk("bad2_done", frame_done, 0);
    drive(1'b1, 8'h04);
    chk("bad3_cnt_pre", bad_cmd_cnt, 2);
    drive(1'b0, 8'h00);
    chk("bad3_cnt",  bad_cmd_cnt, 3);
    chk("bad3_done", frame_done,  0);
    drive(1'b0, 8'h00);

    // Short write frame: ends before payload index.
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    chk("short_route_en", route_en, 0);
    drive(1'b0, 8'h00);
    chk("short_done",    frame_done, 1);
    chk("short_len_err", len_err,    1);
    chk("short_ch",      frame_ch,   4);
    drive(1'b0, 8'h00);
    chk("short_len_err_pulse", len_err, 0);

    // Back-to-back frames separated by a single idle cycle.
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hE0);
    chk("b2b_a_e0", route_en, 8'h80);
    drive(1'b1, 8'hE1);
    chk("b2b_a_e1", route_dout, 8'hE1);
    drive(1'b0, 8'h00);
    chk("b2b_a_done", frame_done, 1);
    chk("b2b_a_ch",   frame_ch,   7);
    drive(1'b1, 8'h04);
    chk("b2b_b_done_low", frame_done, 0);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hF0);
    chk("b2b_b_en",   route_en,   8'h02);
    chk("b2b_b_dout", route_dout, 8'hF0);
    drive(1'b0, 8'h00);
    chk("b2b_b_done", frame_done, 1);
    chk("b2b_b_ch",   frame_ch,   1);
    chk("b2b_bad_cnt", bad_cmd_cnt, 3);
    drive(1'b0, 8'h00);

    // Reset pulse in the middle of a payload while the frame continues.
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h50);
    chk("mid_p0_en", route_en, 8'h40);
    rst = 1'b1;
    drive(1'b1, 8'h51);
    chk("mid_rst_en",   route_en,    0);
    chk("mid_rst_dout", route_dout,  0);
    chk("mid_rst_bad",  bad_cmd_cnt, 0);
    chk("mid_rst_ch",   frame_ch,    0);
    rst = 1'b0;
    drive(1'b1, 8'h52);
    chk("mid_tail_en0", route_en, 0);
    drive(1'b1, 8'h53);
    chk("mid_tail_en1", route_en, 0);
    drive(1'b0, 8'h00);
    chk("mid_tail_done", frame_done,  0);
    chk("mid_tail_bad",  bad_cmd_cnt, 0);
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h99);
    chk("post_rst_en",   route_en,   8'h20);
    chk("post_rst_dout", route_dout, 8'h99);
    drive(1'b0, 8'h00);
    chk("post_rst_done", frame_done, 1);
    chk("post_rst_ch",   frame_ch,   5);
    drive(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
